// File: rtl/fdc_disk_responder_if.sv
// ============================================================================
// Module   : fdc_disk_responder_if
// Brief    : Byte-wide request/acknowledge port to the disk-image memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fdc_disk_responder_if;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/fdc_disk_responder.sv
// ============================================================================
// Module   : fdc_disk_responder
// Brief    : Disk-side sector server for the nec765 FDC; two drives backed by
//            a flat byte-addressed image memory. FDR_SEEK_DELAY_EN enables
//            distance-proportional seek timing.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fdc_disk_responder #(
  parameter int         SPT         = 9,
  parameter int         SIDES       = 1,
  parameter int         TRACKS      = 40,
  parameter logic [7:0] ID_BASE     = 8'hC1,
  parameter int         DRIVE_SHIFT = 20,
  parameter int         FIFO_LAT    = 1,
  parameter int         STEP_CYCLES = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disk_sr,
  output logic [31:0] disk_cr,
  input  logic [1:0]  disk_present,
  output logic [7:0]  disk_data_in,
  output logic        disk_data_clkin,
  input  logic [7:0]  disk_data_out,
  output logic        disk_data_clkout,
  fdc_disk_responder_if.master mem
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_RD_PUSH, S_WR_PULL, S_WR_CAP,
    S_WR_REQ, S_WR_WAIT, S_SEEK, S_SEEK_FIN, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [6:0]  r_prev;
  logic [7:0]  r_rot, r_cr_id, r_id, r_data, r_lat;
  logic [6:0]  r_cyl;
  logic [6:0]  r_cyl_reg [2];
  logic        r_head, r_drv, r_is_wr, r_seek_err, r_done, r_err, r_cr_p0;
  logic [15:0] r_lba;
  logic [9:0]  r_byte_cnt, w_cnt_nxt;
  logic        w_fin, w_fin_err, w_seek_busy;

  // {seek drv1, seek drv0, next-ID toggle, wr drv1, wr drv0, rd drv1, rd drv0}
  logic [6:0] w_req;
  logic       w_rd_edge, w_wr_edge, w_sk_edge, w_toggle, w_quiet, w_chk_err;
  logic       w_unused_sr;

  assign w_req       = {disk_sr[25:24], disk_sr[22], disk_sr[21:20], disk_sr[18:17]};
  assign w_rd_edge   = |(w_req[1:0] & ~r_prev[1:0]);
  assign w_wr_edge   = |(w_req[3:2] & ~r_prev[3:2]);
  assign w_sk_edge   = (r_prev[6:5] == 2'b00) && (w_req[6:5] != 2'b00);
  assign w_toggle    = w_req[4] ^ r_prev[4];
  assign w_quiet     = (w_req[3:0] == 4'd0) && (w_req[6:5] == 2'b00);
  assign w_cnt_nxt   = r_byte_cnt + 10'd1;
  assign w_unused_sr = ^{disk_sr[31:26], disk_sr[23], disk_sr[19], disk_sr[16]};

  assign w_chk_err = !disk_present[r_drv]
                   || (32'(r_id) < 32'(ID_BASE))
                   || (32'(r_id) >= 32'(ID_BASE) + 32'(SPT))
                   || (32'(r_cyl) >= 32'(TRACKS))
                   || (32'(r_head) >= 32'(SIDES));

  assign mem.mem_addr  = (24'(r_drv) << DRIVE_SHIFT) | (24'(r_lba) << 9)
                       | {15'd0, r_byte_cnt[8:0]};
  assign mem.mem_wdata = r_data;
  assign disk_data_in  = r_data;
  assign disk_cr       = {r_cr_id, 18'd0, r_cr_p0, r_done, r_err, 3'd0};

`ifdef FDR_SEEK_DELAY_EN
  logic [23:0] r_seek_cnt;
  logic [6:0]  w_cur_cyl, w_dist;

  assign w_cur_cyl = r_cyl_reg[disk_sr[25]];
  assign w_dist    = (disk_sr[14:8] >= w_cur_cyl) ? (disk_sr[14:8] - w_cur_cyl)
                                                  : (w_cur_cyl - disk_sr[14:8]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seek_cnt <= 24'd0;
    end else if (r_state == S_IDLE && w_next == S_SEEK) begin
      r_seek_cnt <= 24'(32'(w_dist) * 32'(STEP_CYCLES));
    end else if (r_state == S_SEEK && r_seek_cnt != 24'd0) begin
      r_seek_cnt <= r_seek_cnt - 24'd1;
    end
  end
  assign w_seek_busy = (r_seek_cnt != 24'd0);
`else
  logic w_unused_seek;
  // Cylinder tracking only feeds the seek timer, absent in this build.
  assign w_unused_seek = ^{32'(STEP_CYCLES), r_cyl_reg[0], r_cyl_reg[1]};
  assign w_seek_busy   = 1'b0;
`endif

  always_comb begin
    w_next               = r_state;
    w_fin                = 1'b0;
    w_fin_err            = 1'b0;
    mem.mem_rd           = 1'b0;
    mem.mem_wr           = 1'b0;
    disk_data_clkin      = 1'b0;
    disk_data_clkout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_edge || w_rd_edge) w_next = S_CHECK;
        else if (w_sk_edge)         w_next = S_SEEK;
      end
      S_CHECK: begin
        if (w_chk_err) begin
          w_next    = S_DONE;
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else begin
          w_next = r_is_wr ? S_WR_PULL : S_RD_REQ;
        end
      end
      // An ack arriving in the request cycle itself is accepted.
      S_RD_REQ, S_RD_WAIT: begin
        mem.mem_rd = 1'b1;
        w_next     = mem.mem_ack ? S_RD_PUSH : S_RD_WAIT;
      end
      S_RD_PUSH: begin
        disk_data_clkin = 1'b1;
        if (w_cnt_nxt == 10'd512) begin
          w_next = S_DONE;
          w_fin  = 1'b1;
        end else begin
          w_next = S_RD_REQ;
        end
      end
      S_WR_PULL: begin
        disk_data_clkout = 1'b1;
        w_next           = S_WR_CAP;
      end
      S_WR_CAP: if (r_lat == 8'd0) w_next = S_WR_REQ;
      S_WR_REQ, S_WR_WAIT: begin
        mem.mem_wr = 1'b1;
        if (!mem.mem_ack) begin
          w_next = S_WR_WAIT;
        end else if (w_cnt_nxt == 10'd512) begin
          w_next = S_DONE;
          w_fin  = 1'b1;
        end else begin
          w_next = S_WR_PULL;
        end
      end
      S_SEEK:     w_next = w_seek_busy ? S_SEEK : S_SEEK_FIN;
      S_SEEK_FIN: begin
        w_next    = S_DONE;
        w_fin     = 1'b1;
        w_fin_err = r_seek_err;
      end
      S_DONE:  if (w_quiet) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prev       <= 7'd0;
      r_rot        <= 8'd0;
      r_cr_id      <= 8'd0;
      r_cr_p0      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_id         <= 8'd0;
      r_cyl        <= 7'd0;
      r_head       <= 1'b0;
      r_drv        <= 1'b0;
      r_is_wr      <= 1'b0;
      r_seek_err   <= 1'b0;
      r_lba        <= 16'd0;
      r_byte_cnt   <= 10'd0;
      r_data       <= 8'd0;
      r_lat        <= 8'd0;
      r_cyl_reg[0] <= 7'd0;
      r_cyl_reg[1] <= 7'd0;
    end else begin
      r_state <= w_next;
      r_prev  <= w_req;
      if (w_toggle) r_rot <= (r_rot == 8'(SPT - 1)) ? 8'd0 : r_rot + 8'd1;
      r_cr_id <= disk_present[0] ? ID_BASE + r_rot : 8'd0;
      r_cr_p0 <= disk_present[0];

      if (w_fin) begin
        r_done <= 1'b1;
        r_err  <= w_fin_err;
      end else if (r_state == S_DONE && w_quiet) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_next == S_CHECK) begin
            r_is_wr    <= w_wr_edge;
            r_drv      <= w_wr_edge ? disk_sr[21] : disk_sr[18];
            r_id       <= disk_sr[7:0];
            r_cyl      <= disk_sr[14:8];
            r_head     <= disk_sr[15];
            r_byte_cnt <= 10'd0;
          end else if (w_next == S_SEEK) begin
            r_drv                   <= disk_sr[25];
            r_seek_err              <= !disk_present[disk_sr[25]];
            r_cyl_reg[disk_sr[25]]  <= disk_sr[14:8];
          end
        end
        S_CHECK: r_lba <= 16'((32'(r_cyl) * 32'(SIDES) + 32'(r_head)) * 32'(SPT)
                              + 32'(r_id) - 32'(ID_BASE));
        S_RD_REQ, S_RD_WAIT: if (mem.mem_ack) r_data <= mem.mem_rdata;
        S_RD_PUSH: r_byte_cnt <= w_cnt_nxt;
        S_WR_PULL: r_lat <= 8'(FIFO_LAT - 1);
        S_WR_CAP: begin
          if (r_lat == 8'd0) r_data <= disk_data_out;
          else               r_lat  <= r_lat - 8'd1;
        end
        S_WR_REQ, S_WR_WAIT: if (mem.mem_ack) r_byte_cnt <= w_cnt_nxt;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
